// File: rtl/bus32_arbiter_if.sv
// rtl/bus32_arbiter_if.sv - request/grant/output-enable bundle between the arbiter and the bus sources
interface bus32_arbiter_if #(
  parameter int N = 8
);
  localparam int OW = (N > 1) ? $clog2(N) : 1;

  logic [N-1:0]  req;
  logic [N-1:0]  gnt;
  logic [N-1:0]  g;
  logic [OW-1:0] owner;
  logic          busy;
  logic          timeout;

  modport master (
    input  req,
    output gnt,
    output g,
    output owner,
    output busy,
    output timeout
  );

  modport slave (
    output req,
    input  gnt,
    input  g,
    input  owner,
    input  busy,
    input  timeout
  );
endinterface

// File: rtl/bus32_arbiter.sv
// rtl/bus32_arbiter.sv - round-robin owner sequencer for the shared 32-bit tri-state source bus
module bus32_arbiter #(
  parameter int N           = 8,
  parameter int TURN_CYCLES = 1,
  parameter int HOLD_MAX    = 16
) (
  input logic             clk,
  input logic             rst_n,
  bus32_arbiter_if.master bus
);
  localparam int OW = (N > 1) ? $clog2(N) : 1;
  localparam int HW = (HOLD_MAX > 1) ? $clog2(HOLD_MAX) : 1;
  localparam int TW = (TURN_CYCLES > 1) ? $clog2(TURN_CYCLES) : 1;
  localparam logic [HW-1:0] HOLD_SAT = (HOLD_MAX > 0) ? HW'(HOLD_MAX - 1) : '1;
  localparam logic [TW-1:0] TURN_LIM = TW'(TURN_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, GRANT, TURN} state_t;

  state_t        state;
  logic [OW-1:0] ptr;
  logic [HW-1:0] hold_cnt;
  logic [TW-1:0] turn_cnt;
  logic [N-1:0]  gnt_r;
  logic [N-1:0]  g_r;
  logic [OW-1:0] owner_r;
  logic          busy_r;
  logic          timeout_r;

  logic          win_found;
  logic [OW-1:0] win_idx;
  logic [N-1:0]  win_onehot;
  logic          owner_req;
  logic          others_req;
  logic          force_rel;

  // Scan starts just past the last owner so it is the lowest-priority candidate.
  always_comb begin
    logic [OW-1:0] idx;
    win_found = 1'b0;
    win_idx   = '0;
    idx       = '0;
    for (int k = 1; k <= N; k++) begin
      idx = OW'((int'(ptr) + k) % N);
      if (!win_found && bus.req[idx]) begin
        win_found = 1'b1;
        win_idx   = idx;
      end
    end
  end

  assign win_onehot = N'(1) << win_idx;
  assign owner_req  = |(bus.req & gnt_r);
  assign others_req = |(bus.req & ~gnt_r);
  assign force_rel  = (HOLD_MAX > 0) && (hold_cnt == HOLD_SAT) && others_req;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      ptr       <= OW'(N - 1);
      hold_cnt  <= '0;
      turn_cnt  <= '0;
      gnt_r     <= '0;
      g_r       <= '1;
      owner_r   <= '0;
      busy_r    <= 1'b0;
      timeout_r <= 1'b0;
    end else begin
      timeout_r <= 1'b0;
      case (state)
        IDLE: begin
          if (win_found) begin
            state    <= GRANT;
            gnt_r    <= win_onehot;
            g_r      <= ~win_onehot;
            owner_r  <= win_idx;
            ptr      <= win_idx;
            hold_cnt <= '0;
            busy_r   <= 1'b1;
          end else begin
            busy_r <= 1'b0;
          end
        end
        GRANT: begin
          // A voluntary drop wins over a coincident timeout, so no pulse then.
          if (!owner_req || force_rel) begin
            state     <= TURN;
            gnt_r     <= '0;
            g_r       <= '1;
            turn_cnt  <= '0;
            busy_r    <= 1'b1;
            timeout_r <= owner_req;
          end else if (hold_cnt != HOLD_SAT) begin
            hold_cnt <= hold_cnt + 1'b1;
          end
        end
        TURN: begin
          if (turn_cnt == TURN_LIM) begin
            if (win_found) begin
              state    <= GRANT;
              gnt_r    <= win_onehot;
              g_r      <= ~win_onehot;
              owner_r  <= win_idx;
              ptr      <= win_idx;
              hold_cnt <= '0;
              busy_r   <= 1'b1;
            end else begin
              state  <= IDLE;
              busy_r <= 1'b0;
            end
          end else begin
            turn_cnt <= turn_cnt + 1'b1;
          end
        end
        default: begin
          state  <= IDLE;
          gnt_r  <= '0;
          g_r    <= '1;
          busy_r <= 1'b0;
        end
      endcase
    end
  end

  assign bus.gnt     = gnt_r;
  assign bus.g       = g_r;
  assign bus.owner   = owner_r;
  assign bus.busy    = busy_r;
  assign bus.timeout = timeout_r;
endmodule

// File: tb/tb_bus32_arbiter.sv
// tb/tb_bus32_arbiter.sv - randomized model-checked bench for bus32_arbiter (two parameter sets)
module tb_bus32_arbiter;
  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  bus32_arbiter_if #(.N(8)) bus_a ();
  bus32_arbiter_if #(.N(8)) bus_b ();

  bus32_arbiter #(.N(8), .TURN_CYCLES(1), .HOLD_MAX(4)) u_a (
    .clk(clk), .rst_n(rst_n), .bus(bus_a)
  );
  bus32_arbiter #(.N(8), .TURN_CYCLES(3), .HOLD_MAX(0)) u_b (
    .clk(clk), .rst_n(rst_n), .bus(bus_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Owner/hold/gap model: gap counts remaining dead cycles down to the arbitration cycle.
  typedef struct {
    int own;
    bit granted;
    int held;
    int gap;
    int ptr;
    bit to;
  } mdl_t;

  mdl_t ma;
  mdl_t mb;

  function automatic int pick(input int p, input logic [7:0] r);
    for (int k = 1; k <= 8; k++)
      if (r[(p + k) % 8]) return (p + k) % 8;
    return -1;
  endfunction

  task automatic mstep(input mdl_t mi, input logic [7:0] r, input int turn, input int hold,
                       output mdl_t mo);
    mdl_t m;
    int   w;
    m    = mi;
    m.to = 1'b0;
    if (m.granted) begin
      if (!r[m.own]) begin
        m.granted = 1'b0;
        m.gap     = turn;
      end else if (hold > 0 && m.held >= hold - 1 && (r & ~(8'b1 << m.own)) != 8'h00) begin
        m.granted = 1'b0;
        m.gap     = turn;
        m.to      = 1'b1;
      end else begin
        m.held++;
      end
    end else if (m.gap > 1) begin
      m.gap--;
    end else begin
      m.gap = 0;
      w     = pick(m.ptr, r);
      if (w >= 0) begin
        m.granted = 1'b1;
        m.own     = w;
        m.ptr     = w;
        m.held    = 0;
      end
    end
    mo = m;
  endtask

  function automatic logic [20:0] exp_vec(input mdl_t m);
    logic [7:0] gg;
    gg = m.granted ? (8'b1 << m.own) : 8'h00;
    return {~gg, gg, 3'(m.own), m.granted || (m.gap > 0), m.to};
  endfunction

  function automatic logic [20:0] dut_a_vec();
    return {bus_a.g, bus_a.gnt, bus_a.owner, bus_a.busy, bus_a.timeout};
  endfunction

  function automatic logic [20:0] dut_b_vec();
    return {bus_b.g, bus_b.gnt, bus_b.owner, bus_b.busy, bus_b.timeout};
  endfunction

  task automatic model_reset();
    ma = '{own: 0, granted: 1'b0, held: 0, gap: 0, ptr: 7, to: 1'b0};
    mb = ma;
  endtask

  // Drive at negedge, advance models on the posedge, return at the next negedge.
  task automatic tick(input logic [7:0] r);
    bus_a.req = r;
    bus_b.req = r;
    @(posedge clk);
    mstep(ma, r, 1, 4, ma);
    mstep(mb, r, 3, 0, mb);
    @(negedge clk);
  endtask

  task automatic test_reset();
    bus_a.req = 8'h00;
    bus_b.req = 8'h00;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    total++;
    if (dut_a_vec() !== {8'hFF, 8'h00, 3'd0, 1'b0, 1'b0} || dut_b_vec() !== {8'hFF, 8'h00, 3'd0, 1'b0, 1'b0}) begin
      $display("FAIL reset_state a=%h b=%h want=%h", dut_a_vec(), dut_b_vec(), {8'hFF, 8'h00, 3'd0, 2'b00});
      bad++;
    end
    rst_n = 1'b1;
    model_reset();
    tick(8'h08);
    total++;
    if (bus_a.gnt !== 8'h08 || bus_a.owner !== 3'd3 || bus_b.gnt !== 8'h08) begin
      $display("FAIL first_grant a=%h/%0d b=%h want 08/3", bus_a.gnt, bus_a.owner, bus_b.gnt);
      bad++;
    end
    tick(8'h08);
    #2 rst_n = 1'b0;
    #1;
    total++;
    if (bus_a.gnt !== 8'h00 || bus_a.g !== 8'hFF || bus_a.busy !== 1'b0 || bus_a.owner !== 3'd0 ||
        bus_b.gnt !== 8'h00 || bus_b.g !== 8'hFF) begin
      $display("FAIL async_reset a_gnt=%h a_g=%h a_busy=%b b_g=%h want 00/FF/0/FF",
               bus_a.gnt, bus_a.g, bus_a.busy, bus_b.g);
      bad++;
    end
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    tick(8'h08);
    total++;
    if (bus_a.gnt !== 8'h08 || bus_a.owner !== 3'd3) begin
      $display("FAIL regrant_after_reset gnt=%h owner=%0d want 08/3", bus_a.gnt, bus_a.owner);
      bad++;
    end
    for (int c = 0; c < 5; c++) begin
      tick(8'h00);
      total++;
      if (dut_a_vec() !== exp_vec(ma) || dut_b_vec() !== exp_vec(mb)) begin
        $display("FAIL reset_drain a=%h/%h b=%h/%h", dut_a_vec(), exp_vec(ma), dut_b_vec(), exp_vec(mb));
        bad++;
      end
    end
  endtask

  task automatic test_round_robin();
    int         order[$];
    int         gap;
    int         run;
    logic [7:0] prev;
    logic [7:0] r;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    gap  = 0;
    run  = 0;
    prev = 8'h00;
    for (int c = 0; c < 60 && order.size() < 9; c++) begin
      r = 8'hFF;
      if (ma.granted && ma.held == 1) r[ma.own] = 1'b0;
      tick(r);
      total++;
      if (dut_a_vec() !== exp_vec(ma) || dut_b_vec() !== exp_vec(mb)) begin
        $display("FAIL rr_model a=%h/%h b=%h/%h", dut_a_vec(), exp_vec(ma), dut_b_vec(), exp_vec(mb));
        bad++;
      end
      if (bus_a.gnt != 8'h00 && prev == 8'h00) begin
        if (order.size() > 0) begin
          total++;
          if (gap !== 1) begin
            $display("FAIL rr_gap got=%0d want=1", gap);
            bad++;
          end
        end
        order.push_back(int'(bus_a.owner));
        run = 0;
        gap = 0;
      end
      if (bus_a.gnt == 8'h00) gap++;
      else run++;
      if (bus_a.gnt == 8'h00 && prev != 8'h00) begin
        total++;
        if (run !== 2) begin
          $display("FAIL rr_hold got=%0d want=2", run);
          bad++;
        end
      end
      prev = bus_a.gnt;
    end
    total++;
    if (order.size() != 9) begin
      $display("FAIL rr_count got=%0d want=9", order.size());
      bad++;
    end else begin
      for (int i = 0; i < 9; i++) begin
        total++;
        if (order[i] !== i % 8) begin
          $display("FAIL rr_order idx=%0d got=%0d want=%0d", i, order[i], i % 8);
          bad++;
        end
      end
    end
    for (int c = 0; c < 5; c++) tick(8'h00);
  endtask

  task automatic test_release_idle();
    int n;
    n = 0;
    for (int c = 0; c < 10; c++) begin
      tick(c < 5 ? 8'h04 : 8'h00);
      total++;
      if (dut_a_vec() !== exp_vec(ma) || dut_b_vec() !== exp_vec(mb) || $countones(~bus_a.g) > 1) begin
        $display("FAIL release_model a=%h/%h b=%h/%h", dut_a_vec(), exp_vec(ma), dut_b_vec(), exp_vec(mb));
        bad++;
      end
      if (bus_a.gnt == 8'h04) n++;
    end
    total++;
    if (n !== 5 || bus_a.busy !== 1'b0 || bus_b.busy !== 1'b0) begin
      $display("FAIL release_idle cycles=%0d busy_a=%b busy_b=%b want 5/0/0", n, bus_a.busy, bus_b.busy);
      bad++;
    end
  endtask

  task automatic test_timeout();
    int hcnt;
    int seen_to;
    bit prev_to;
    bit got5;
    tick(8'h02);
    hcnt    = (bus_a.gnt == 8'h02) ? 1 : 0;
    seen_to = 0;
    prev_to = 1'b0;
    got5    = 1'b0;
    for (int c = 0; c < 6; c++) begin
      tick(8'h22);
      total++;
      if (dut_a_vec() !== exp_vec(ma) || dut_b_vec() !== exp_vec(mb)) begin
        $display("FAIL timeout_model a=%h/%h b=%h/%h", dut_a_vec(), exp_vec(ma), dut_b_vec(), exp_vec(mb));
        bad++;
      end
      if (bus_a.gnt == 8'h02 && seen_to == 0) hcnt++;
      if (prev_to && bus_a.gnt == 8'h20) got5 = 1'b1;
      if (bus_a.timeout === 1'b1) seen_to++;
      prev_to = bus_a.timeout;
    end
    total++;
    if (hcnt !== 4 || seen_to !== 1 || !got5) begin
      $display("FAIL timeout_seq hold=%0d pulses=%0d next5=%0d want 4/1/1", hcnt, seen_to, got5);
      bad++;
    end
    for (int c = 0; c < 5; c++) tick(8'h00);
    for (int c = 0; c < 30; c++) begin
      tick(8'h02);
      total++;
      if (bus_a.gnt !== 8'h02 || bus_a.timeout !== 1'b0) begin
        $display("FAIL timeout_lone cyc=%0d gnt=%h to=%b want 02/0", c, bus_a.gnt, bus_a.timeout);
        bad++;
      end
    end
    for (int c = 0; c < 5; c++) tick(8'h00);
  endtask

  task automatic test_turnaround();
    int  ff;
    bit  fell;
    bit  done;
    for (int c = 0; c < 3; c++) tick(8'h01);
    ff   = 0;
    fell = 1'b0;
    done = 1'b0;
    for (int c = 0; c < 10 && !done; c++) begin
      tick(8'h02);
      total++;
      if (dut_a_vec() !== exp_vec(ma) || dut_b_vec() !== exp_vec(mb)) begin
        $display("FAIL turn_model a=%h/%h b=%h/%h", dut_a_vec(), exp_vec(ma), dut_b_vec(), exp_vec(mb));
        bad++;
      end
      if (bus_b.g == 8'hFF) begin
        fell = 1'b1;
        ff++;
      end else if (fell && bus_b.gnt == 8'h02) begin
        done = 1'b1;
      end
    end
    total++;
    if (ff !== 3 || !done) begin
      $display("FAIL turn_len ff_cycles=%0d regrant=%0d want 3/1", ff, done);
      bad++;
    end
    for (int c = 0; c < 5; c++) tick(8'h00);
  endtask

  task automatic test_simultaneous();
    tick(8'h02);
    for (int c = 0; c < 3; c++) tick(8'h22);
    tick(8'h20);
    total++;
    if (bus_a.timeout !== 1'b0 || bus_a.gnt !== 8'h00 || bus_a.busy !== 1'b1) begin
      $display("FAIL drop_at_timeout to=%b gnt=%h busy=%b want 0/00/1", bus_a.timeout, bus_a.gnt, bus_a.busy);
      bad++;
    end
    tick(8'h20);
    total++;
    if (bus_a.gnt !== 8'h20 || bus_a.owner !== 3'd5) begin
      $display("FAIL drop_then_grant gnt=%h owner=%0d want 20/5", bus_a.gnt, bus_a.owner);
      bad++;
    end
    for (int c = 0; c < 5; c++) tick(8'h00);
    tick(8'h01);
    tick(8'h01);
    tick(8'h00);
    for (int c = 0; c < 2; c++) begin
      tick((8'($urandom) & 8'hF7) | 8'h04);
      total++;
      if (dut_a_vec() !== exp_vec(ma) || bus_b.gnt !== 8'h00) begin
        $display("FAIL turn_ignore a=%h/%h b_gnt=%h want 00", dut_a_vec(), exp_vec(ma), bus_b.gnt);
        bad++;
      end
    end
    tick(8'h08);
    total++;
    if (bus_b.gnt !== 8'h08 || bus_b.owner !== 3'd3) begin
      $display("FAIL final_sample gnt=%h owner=%0d want 08/3", bus_b.gnt, bus_b.owner);
      bad++;
    end
    for (int c = 0; c < 5; c++) tick(8'h00);
  endtask

  task automatic test_random();
    logic [7:0] r;
    logic [7:0] pa;
    r  = 8'h00;
    pa = 8'hFF;
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < 8; i++)
        if ($urandom_range(0, 7) == 0) r[i] = ~r[i];
      tick(r);
      total++;
      if (dut_a_vec() !== exp_vec(ma) || dut_b_vec() !== exp_vec(mb)) begin
        $display("FAIL random_model cyc=%0d req=%h a=%h/%h b=%h/%h", c, r, dut_a_vec(), exp_vec(ma),
                 dut_b_vec(), exp_vec(mb));
        bad++;
      end
      total++;
      if ($countones(~bus_a.g) > 1 || (pa != 8'hFF && bus_a.g != 8'hFF && pa != bus_a.g)) begin
        $display("FAIL random_overlap prev_g=%h g=%h", pa, bus_a.g);
        bad++;
      end
      pa = bus_a.g;
    end
    for (int c = 0; c < 5; c++) tick(8'h00);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  initial begin
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    bus_a.req = 8'h00;
    bus_b.req = 8'h00;
    model_reset();
    @(negedge clk);
    test_reset();
    test_round_robin();
    test_release_idle();
    test_timeout();
    test_turnaround();
    test_simultaneous();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
